m_game_scheduler: RTL and testbench
===================================

Name: m_game_scheduler

Overview:
Top-level round sequencer for the maze game. Divides the 50 MHz clock into game ticks. On each tick it runs one pass of the game-logic FSM, then one ghost-collision check. It also tracks lives, win/lose and respawn, and reports status to the VGA/HEX display path. All enables it drives are level signals with explicit completion handshakes.

Parameters:
TICK_CYCLES, 5000000, clock cycles per game tick (10 Hz at 50 MHz); minimum 2
TIMEOUT, 255, max cycles to wait for logic_finished before forcing progress
START_LIVES, 3, lives loaded on start; 1..3
FOOD_TOTAL, 150, score value at which the round is won
HIT_TICKS, 10, ticks frozen after a ghost hit before play resumes

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  start/restart request, level, sampled each cycle
pause  in  1  freezes tick counting while high
logic_enable  out  1  enable to game-logic FSM
logic_finished  in  1  completion pulse/level from game logic
collide_enable  out  1  enable to ghost-collision checker
ghost_collision  in  1  collision flag from checker
score  in  8  current score from game logic
respawn  out  1  one-cycle pulse: reset player/ghost positions
lives  out  2  remaining lives
game_over  out  1  high in OVER state
game_won  out  1  high in WON state
timeout_err  out  1  sticky: a logic pass timed out
tick_count  out  16  ticks executed since start, wraps at 65535->0

Behaviour:
- Async reset, all registers: state=IDLE, all outputs 0, lives=0, tick/timeout counters 0.
- States: IDLE, WAIT_TICK, RUN_LOGIC, CHECK, HIT, OVER, WON. All outputs are registered.
- IDLE: start=1 -> WAIT_TICK next cycle. On that transition: lives<=START_LIVES, tick_count<=0, timeout_err<=0, respawn pulses 1 cycle.
- WAIT_TICK: divider counts 0..TICK_CYCLES-1 while pause=0; holds its value while pause=1. At terminal count it returns to 0 and state moves to RUN_LOGIC. logic_enable=1 in the same cycle RUN_LOGIC is entered. tick_count increments on that entry.
- RUN_LOGIC: logic_enable held 1. logic_finished=1 seen -> logic_enable=0 next cycle, state CHECK. Timeout counter increments each RUN_LOGIC cycle. If it reaches TIMEOUT without finished: timeout_err<=1 (sticky), state CHECK. The counter clears on exit. pause is ignored in this state; a pass always completes.
- CHECK: lasts exactly 2 cycles, collide_enable=1 in both. ghost_collision is sampled on the 2nd cycle. Resolution order is collision first, then win:
  - collision=1, lives>1: lives-1, respawn pulse, state HIT.
  - collision=1, lives==1: lives<=0, state OVER.
  - no collision, score>=FOOD_TOTAL: state WON.
  - otherwise: state WAIT_TICK.
- Simultaneous collision and final food: loss of life wins.
- HIT: divider keeps running. After HIT_TICKS full ticks, go to WAIT_TICK with divider=0. No logic passes run in HIT. pause freezes HIT as well.
- OVER/WON: flag held high; logic and collide enables stay 0. start=1 -> IDLE path: the next cycle performs the same initialisation as IDLE+start (go to WAIT_TICK, lives reloaded, respawn pulse).
- start is ignored in all other states.
- Reset mid-operation: immediate return to IDLE values regardless of state, including during the logic_enable handshake.
- Widths: divider is 23 bits. Score compare is unsigned 8-bit. lives never underflows below 0.

Decomposition:
- Shared package/header (game_defs): state encodings, TICK_CYCLES/FOOD_TOTAL defaults, lives width.
- One natural sub-module: m_tick_divider. Ports: clock, resetn, run, clear; outputs tick pulse at terminal count. Used in both WAIT_TICK and HIT.

Test Plan:
Use TICK_CYCLES=4, TIMEOUT=8, START_LIVES=3, FOOD_TOTAL=5, HIT_TICKS=2.
1. Reset, pulse start, logic_finished returned 3 cycles after logic_enable rises, no collision -> logic_enable rises exactly 4 cycles after entering WAIT_TICK; collide_enable high 2 cycles; tick_count=1; lives=3.
2. Hold logic_finished=0 -> after 8 RUN_LOGIC cycles timeout_err=1, CHECK entered, timeout_err stays 1 on later ticks until restart.
3. ghost_collision=1 in CHECK on three successive passes -> lives 3->2->1 with respawn pulses and 2-tick HIT gaps; third hit gives lives=0, game_over=1, no further logic_enable.
4. score=5 with collision=0 -> game_won=1. Repeat with score=5 and collision=1 -> lives decremented, game_won=0.
5. pause=1 for 20 cycles mid-WAIT_TICK -> logic_enable delayed exactly 20 cycles. pause asserted during RUN_LOGIC -> pass still completes.
6. Deassert resetn during RUN_LOGIC -> logic_enable=0 and lives=0 immediately (asynchronous). After release, state is IDLE and start is required.

Source files
------------

// File: rtl/m_game_scheduler_pkg.sv
// Shared definitions for the maze-game round sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m_game_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_RUN_LOGIC,
    ST_CHECK,
    ST_HIT,
    ST_OVER,
    ST_WON
  } state_t;

  localparam int DIV_W   = 23;  // game-tick divider width
  localparam int LIVES_W = 2;
  localparam int SCORE_W = 8;
  localparam int TICK_W  = 16;  // executed-tick counter width
  localparam int TO_W    = 8;   // logic-pass timeout counter width
  localparam int HIT_W   = 8;   // frozen-tick counter width after a ghost hit

  localparam int DEF_TICK_CYCLES = 5000000;  // 10 Hz at 50 MHz
  localparam int DEF_FOOD_TOTAL  = 150;

endpackage

// File: rtl/m_game_scheduler_if.sv
// Handshake bundle between the round sequencer and the game-logic / collision blocks.
// Latency: n/a (wires only).
// Backpressure: enables are levels held until the matching completion is seen.
//   logic_enable / logic_finished   : one game-logic pass
//   collide_enable / ghost_collision: one ghost-collision check
//   score                           : current score from game logic
interface m_game_scheduler_if;
  import m_game_scheduler_pkg::*;

  logic               logic_enable;
  logic               logic_finished;
  logic               collide_enable;
  logic               ghost_collision;
  logic [SCORE_W-1:0] score;

  // master: the scheduler; slave: game logic + collision checker
  modport master (
    output logic_enable, collide_enable,
    input  logic_finished, ghost_collision, score
  );
  modport slave (
    input  logic_enable, collide_enable,
    output logic_finished, ghost_collision, score
  );
endinterface

// File: rtl/m_tick_divider.sv
// Game-tick divider: counts 0..TICK_CYCLES-1 and flags the terminal count.
// Latency: tick is combinational from the count register, asserted in the terminal cycle.
// Backpressure: run=0 holds the count; clear forces it to 0 and wins over run.
//   clock, resetn : clock, async active-low reset
//   run, clear    : count enable, synchronous clear
//   tick          : high in the cycle the counter wraps
module m_tick_divider
  import m_game_scheduler_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_W-1:0] TERM = DIV_W'(TICK_CYCLES - 1);

  logic [DIV_W-1:0] cnt;

  assign tick = run && !clear && (cnt == TERM);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == TERM) ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/m_game_scheduler.sv
// Round sequencer: per game tick runs one logic pass, then a 2-cycle ghost-collision check.
// Latency: logic_enable rises TICK_CYCLES cycles after WAIT_TICK entry; CHECK resolves 2 cycles after finish.
// Backpressure: pause freezes WAIT_TICK/HIT; a logic pass waits for logic_finished up to TIMEOUT cycles.
//   clock, resetn          : clock, async active-low reset
//   start, pause           : level controls from the player
//   gif                    : logic / collision handshake bundle (master side)
//   respawn                : one-cycle position reset pulse
//   lives, game_over, game_won, timeout_err, tick_count : status to the display path
module m_game_scheduler
  import m_game_scheduler_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int TIMEOUT     = 255,
  parameter int START_LIVES = 3,
  parameter int FOOD_TOTAL  = DEF_FOOD_TOTAL,
  parameter int HIT_TICKS   = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  pause,
  m_game_scheduler_if.master    gif,
  output logic                  respawn,
  output logic [LIVES_W-1:0]    lives,
  output logic                  game_over,
  output logic                  game_won,
  output logic                  timeout_err,
  output logic [TICK_W-1:0]     tick_count
);

  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [HIT_W-1:0]   HIT_LAST = HIT_W'(HIT_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES0   = LIVES_W'(START_LIVES);
  localparam logic [SCORE_W-1:0] FOOD_MAX = SCORE_W'(FOOD_TOTAL);

  state_t           state;
  logic [TO_W-1:0]  to_cnt;
  logic [HIT_W-1:0] hit_cnt;
  logic             chk_second;
  logic             div_tick;
  logic             div_active;

  // The divider only runs while waiting for a tick or sitting out a hit;
  // everywhere else it is held at 0 so every wait starts from a full period.
  assign div_active = (state == ST_WAIT_TICK) || (state == ST_HIT);

  m_tick_divider #(.TICK_CYCLES(TICK_CYCLES)) u_div (
    .clock (clock),
    .resetn(resetn),
    .run   (div_active && !pause),
    .clear (!div_active),
    .tick  (div_tick)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state              <= ST_IDLE;
      to_cnt             <= '0;
      hit_cnt            <= '0;
      chk_second         <= 1'b0;
      gif.logic_enable   <= 1'b0;
      gif.collide_enable <= 1'b0;
      respawn            <= 1'b0;
      lives              <= '0;
      game_over          <= 1'b0;
      game_won           <= 1'b0;
      timeout_err        <= 1'b0;
      tick_count         <= '0;
    end else begin
      respawn <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER, ST_WON: begin
          if (start) begin
            state       <= ST_WAIT_TICK;
            lives       <= LIVES0;
            tick_count  <= '0;
            timeout_err <= 1'b0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
            respawn     <= 1'b1;
          end
        end

        ST_WAIT_TICK: begin
          if (div_tick) begin
            state            <= ST_RUN_LOGIC;
            gif.logic_enable <= 1'b1;
            tick_count       <= tick_count + TICK_W'(1);
          end
        end

        ST_RUN_LOGIC: begin
          // A finish in the same cycle as the last allowed one is not a timeout.
          if (gif.logic_finished || (to_cnt == TO_LAST)) begin
            if (!gif.logic_finished) timeout_err <= 1'b1;
            state              <= ST_CHECK;
            gif.logic_enable   <= 1'b0;
            gif.collide_enable <= 1'b1;
            chk_second         <= 1'b0;
            to_cnt             <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        ST_CHECK: begin
          if (!chk_second) begin
            chk_second <= 1'b1;
          end else begin
            chk_second         <= 1'b0;
            gif.collide_enable <= 1'b0;
            // Collision outranks the win: eating the last food while caught still costs a life.
            if (gif.ghost_collision) begin
              if (lives > LIVES_W'(1)) begin
                lives   <= lives - LIVES_W'(1);
                respawn <= 1'b1;
                hit_cnt <= '0;
                state   <= ST_HIT;
              end else begin
                lives     <= '0;
                game_over <= 1'b1;
                state     <= ST_OVER;
              end
            end else if (gif.score >= FOOD_MAX) begin
              game_won <= 1'b1;
              state    <= ST_WON;
            end else begin
              state <= ST_WAIT_TICK;
            end
          end
        end

        ST_HIT: begin
          // Divider wraps to 0 on the last frozen tick, so WAIT_TICK starts clean.
          if (div_tick) begin
            if (hit_cnt == HIT_LAST) begin
              hit_cnt <= '0;
              state   <= ST_WAIT_TICK;
            end else begin
              hit_cnt <= hit_cnt + HIT_W'(1);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m_game_scheduler.sv
// Scoreboard bench for the round sequencer: expectations queued at stimulus, popped at observation.
// Latency: n/a.
// Backpressure: n/a.
module tb_m_game_scheduler;

  localparam int TC = 4;
  localparam int TO = 8;
  localparam int SL = 3;
  localparam int FT = 5;
  localparam int HT = 2;

  logic        clock;
  logic        resetn;
  logic        start;
  logic        pause;
  logic        respawn;
  logic [1:0]  lives;
  logic        game_over;
  logic        game_won;
  logic        timeout_err;
  logic [15:0] tick_count;

  m_game_scheduler_if gif();

  m_game_scheduler #(
    .TICK_CYCLES(TC), .TIMEOUT(TO), .START_LIVES(SL), .FOOD_TOTAL(FT), .HIT_TICKS(HT)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .pause      (pause),
    .gif        (gif.master),
    .respawn    (respawn),
    .lives      (lives),
    .game_over  (game_over),
    .game_won   (game_won),
    .timeout_err(timeout_err),
    .tick_count (tick_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // model state
  int exp_lives = 0;
  int exp_tc    = 0;
  int exp_wait  = TC;
  bit exp_err   = 1'b0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input int got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, got, e.val);
    end
  endtask

  // negedges until logic_enable is seen high, bounded
  task automatic wait_le(output int n);
    n = 0;
    while (!gif.logic_enable && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_lives = SL;
    exp_tc    = 0;
    exp_err   = 1'b0;
    exp_wait  = TC;
    sb_push("start_respawn", 1);
    sb_push("start_lives", SL);
    sb_push("start_tick_count", 0);
    sb_push("start_timeout_err", 0);
    sb_push("start_game_over", 0);
    sb_push("start_game_won", 0);
    sb_pop_chk(respawn);
    sb_pop_chk(lives);
    sb_pop_chk(tick_count);
    sb_pop_chk(timeout_err);
    sb_pop_chk(game_over);
    sb_pop_chk(game_won);
  endtask

  // One game tick: wait for logic_enable, answer after d cycles (d<0: never),
  // then present the collision flag for the check.
  task automatic run_pass(input int d, input bit coll, input int sc, input bit pz);
    int n;
    bit hit;
    bit dies;
    bit ok;
    ok   = (d >= 0) && (d < TO);
    hit  = coll && (exp_lives > 1);
    dies = coll && (exp_lives == 1);
    if (!ok) exp_err = 1'b1;
    exp_tc = (exp_tc + 1) & 16'hffff;
    sb_push("gap", exp_wait);
    sb_push("tick_count", exp_tc);
    sb_push("run_len", ok ? d + 1 : TO);
    sb_push("collide_c1", 1);
    sb_push("collide_c2", 1);
    sb_push("collide_off", 0);
    if (coll) exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
    sb_push("lives", exp_lives);
    sb_push("game_over", dies);
    sb_push("game_won", (!coll && sc >= FT) ? 1 : 0);
    sb_push("respawn", hit);
    sb_push("timeout_err", exp_err);
    exp_wait = hit ? (HT + 1) * TC : TC;

    wait_le(n);
    sb_pop_chk(n);
    sb_pop_chk(tick_count);
    gif.score           = 8'(sc);
    gif.ghost_collision = coll;
    pause               = pz;
    n = 0;
    while (gif.logic_enable && n < 4 * TO) begin
      gif.logic_finished = (d >= 0) && (n == d);
      n++;
      @(negedge clock);
    end
    gif.logic_finished = 1'b0;
    pause              = 1'b0;
    sb_pop_chk(n);
    sb_pop_chk(gif.collide_enable);
    @(negedge clock);
    sb_pop_chk(gif.collide_enable);
    @(negedge clock);
    sb_pop_chk(gif.collide_enable);
    sb_pop_chk(lives);
    sb_pop_chk(game_over);
    sb_pop_chk(game_won);
    sb_pop_chk(respawn);
    sb_pop_chk(timeout_err);
    gif.ghost_collision = 1'b0;
  endtask

  // Terminal states must never launch another pass.
  task automatic quiet(input int cycles, input int over, input int won);
    int hi;
    hi = 0;
    sb_push("quiet_logic_enable", 0);
    sb_push("quiet_game_over", over);
    sb_push("quiet_game_won", won);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (gif.logic_enable) hi++;
    end
    sb_pop_chk(hi);
    sb_pop_chk(game_over);
    sb_pop_chk(game_won);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn              = 1'b0;
    start               = 1'b0;
    pause               = 1'b0;
    gif.logic_finished  = 1'b0;
    gif.ghost_collision = 1'b0;
    gif.score           = 8'd0;
    repeat (3) @(negedge clock);
    sb_push("reset_lives", 0);
    sb_push("reset_logic_enable", 0);
    sb_push("reset_collide_enable", 0);
    sb_push("reset_game_over", 0);
    sb_push("reset_tick_count", 0);
    sb_pop_chk(lives);
    sb_pop_chk(gif.logic_enable);
    sb_pop_chk(gif.collide_enable);
    sb_pop_chk(game_over);
    sb_pop_chk(tick_count);
    resetn = 1'b1;
    @(negedge clock);

    // basic pass, then timeout, then sticky error
    start_game();
    run_pass(3, 1'b0, 0, 1'b0);
    run_pass(-1, 1'b0, 0, 1'b0);
    run_pass(2, 1'b0, 0, 1'b0);

    // three hits: 3->2->1->0 and game over
    run_pass(3, 1'b1, 0, 1'b0);
    run_pass(3, 1'b1, 0, 1'b0);
    run_pass(3, 1'b1, 0, 1'b0);
    quiet(30, 1, 0);
    check_val("over_timeout_err_sticky", timeout_err, 1);

    // restart from OVER; finish on the last allowed cycle is not a timeout
    start_game();
    run_pass(TO - 1, 1'b0, 0, 1'b0);
    run_pass(3, 1'b1, FT, 1'b0);  // collision with final food: life lost, no win
    run_pass(3, 1'b0, FT, 1'b0);  // win
    quiet(30, 0, 1);

    // restart from WON; 20-cycle pause mid-wait, then pause held through a pass
    start_game();
    repeat (2) @(negedge clock);
    pause = 1'b1;
    repeat (20) @(negedge clock);
    pause    = 1'b0;
    exp_wait = TC - 2;
    run_pass(3, 1'b0, 0, 1'b1);
    run_pass(3, 1'b0, 0, 1'b0);

    // asynchronous reset while logic_enable is high
    sb_push("pre_rst_gap", exp_wait);
    wait_le(n);
    sb_pop_chk(n);
    sb_push("rst_logic_enable", 0);
    sb_push("rst_lives", 0);
    sb_push("rst_tick_count", 0);
    #1 resetn = 1'b0;
    #1;
    sb_pop_chk(gif.logic_enable);
    sb_pop_chk(lives);
    sb_pop_chk(tick_count);
    @(negedge clock);
    resetn = 1'b1;
    quiet(12, 0, 0);
    check_val("idle_lives", lives, 0);
    start_game();
    run_pass(0, 1'b0, 0, 1'b0);

    check_val("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
